// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: assembles MSB-first frames from a qualified
// serial bit stream, pulses p_valid per completed word and flags PATTERN hits.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high; overrides every other input
//   s_in    - serial data bit, sampled only when s_en=1
//   s_en    - bit-qualify strobe
//   flush   - drops the partial frame; the bit on that edge is discarded
//   p_out   - last completed word, first received bit in the MSB
//   p_valid - 1-cycle pulse when p_out is updated
//   match   - 1-cycle pulse with p_valid when the completed word == PATTERN
//   busy    - 1 while a frame is partially received
//   bit_cnt - number of bits in the partial frame (0..WIDTH-1)
module serial_deserializer #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = 8'hA5,
    parameter int               CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_en,
    input  logic             flush,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             match,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             match_q, match_d;

    logic [WIDTH-1:0] word;
    logic             done;

    // Word as it would look after shifting in the current bit.
    assign word = {sr_q[WIDTH-2:0], s_in};
    assign done = (state_q == SHIFT) && s_en && !flush && (cnt_q == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            match_q   <= match_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (s_en) begin
            unique case (state_q)
                IDLE:    state_d = SHIFT;
                SHIFT:   state_d = done ? IDLE : SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        p_out_d   = p_out_q;
        p_valid_d = 1'b0;
        match_d   = 1'b0;
        if (flush) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (s_en) begin
            unique case (state_q)
                IDLE: begin
                    sr_d  = {{(WIDTH-1){1'b0}}, s_in};
                    cnt_d = CNT_W'(1);
                end
                SHIFT: begin
                    if (done) begin
                        sr_d      = '0;
                        cnt_d     = '0;
                        p_out_d   = word;
                        p_valid_d = 1'b1;
                        match_d   = (word == PATTERN);
                    end else begin
                        sr_d  = word;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    sr_d  = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign match   = match_q;
    assign busy    = (state_q == SHIFT);
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed testbench for serial_deserializer (WIDTH=8, PATTERN=8'hA5).
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_in = 1'b0;
    logic       s_en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] p_out;
    logic       p_valid;
    logic       match;
    logic       busy;
    logic [2:0] bit_cnt;

    int total = 0;
    int bad = 0;

    serial_deserializer #(
        .WIDTH  (8),
        .PATTERN(8'hA5),
        .CNT_W  (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_in   (s_in),
        .s_en   (s_en),
        .flush  (flush),
        .p_out  (p_out),
        .p_valid(p_valid),
        .match  (match),
        .busy   (busy),
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, then settle before sampling.
    task automatic step(input logic r, input logic en, input logic b,
                        input logic fl);
        reset = r;
        s_en  = en;
        s_in  = b;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) step(1'b0, 1'b1, v[i], 1'b0);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] po,
                           input logic pv, input logic m, input logic bz,
                           input logic [2:0] bc);
        chk({tag, ".p_out"}, 32'(p_out), 32'(po));
        chk({tag, ".p_valid"}, 32'(p_valid), 32'(pv));
        chk({tag, ".match"}, 32'(match), 32'(m));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(bc));
    endtask

    initial begin
        // T1: reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all("t1_rst", 8'h00, 0, 0, 0, 3'd0);
        step(0, 0, 0, 0);
        chk_all("t1_rel", 8'h00, 0, 0, 0, 3'd0);

        // T2: 0xA5 continuous
        send_bits(8'hA5, 1);
        chk_all("t2_b1", 8'h00, 0, 0, 1, 3'd1);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'hA5;
            if (i > 0) begin
                step(0, 1, v[i], 0);
                chk("t2_novalid", 32'(p_valid), 32'd0);
            end else begin
                step(0, 1, v[i], 0);
            end
        end
        chk_all("t2_done", 8'hA5, 1, 1, 0, 3'd0);
        step(0, 0, 0, 0);
        chk_all("t2_after", 8'hA5, 0, 0, 0, 3'd0);

        // T3: 0x3C with 3-cycle gap after bit 4
        send_bits(8'h3C, 4);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 1, 0);
            chk("t3_gap_cnt", 32'(bit_cnt), 32'd4);
            chk("t3_gap_busy", 32'(busy), 32'd1);
        end
        chk("t3_gap_valid", 32'(p_valid), 32'd0);
        begin
            logic [7:0] v;
            v = 8'h3C;
            for (int i = 3; i >= 0; i--) step(0, 1, v[i], 0);
        end
        chk_all("t3_done", 8'h3C, 1, 0, 0, 3'd0);

        // T4: back-to-back 0xFF then 0x01
        step(0, 0, 0, 0);
        send_bits(8'hFF, 8);
        chk_all("t4_ff", 8'hFF, 1, 0, 0, 3'd0);
        begin
            logic [7:0] v;
            v = 8'h01;
            for (int i = 7; i >= 1; i--) begin
                step(0, 1, v[i], 0);
                chk("t4_gap_valid", 32'(p_valid), 32'd0);
            end
            step(0, 1, v[0], 0);
        end
        chk_all("t4_01", 8'h01, 1, 0, 0, 3'd0);
        step(0, 0, 0, 0);
        chk("t4_after_valid", 32'(p_valid), 32'd0);

        // T5: 5 bits, flush with s_en=1, then 0xA5
        send_bits(8'hFF, 5);
        chk("t5_cnt5", 32'(bit_cnt), 32'd5);
        step(0, 1, 1, 1);
        chk_all("t5_flush", 8'h01, 0, 0, 0, 3'd0);
        // Flush on what would be the completing edge
        send_bits(8'hA5, 7);
        chk("t5_cnt7", 32'(bit_cnt), 32'd7);
        step(0, 1, 1, 1);
        chk_all("t5_flush_last", 8'h01, 0, 0, 0, 3'd0);
        send_bits(8'hA5, 8);
        chk_all("t5_a5", 8'hA5, 1, 1, 0, 3'd0);
        step(0, 0, 0, 0);

        // T6: 6 bits, reset with s_en=1, then fresh frame
        send_bits(8'hFF, 6);
        chk("t6_cnt6", 32'(bit_cnt), 32'd6);
        step(1, 1, 1, 0);
        chk_all("t6_rst", 8'h00, 0, 0, 0, 3'd0);
        send_bits(8'h5A, 7);
        chk_all("t6_b7", 8'h00, 0, 0, 1, 3'd7);
        step(0, 1, 1'b0, 0);
        chk_all("t6_5a", 8'h5A, 1, 0, 0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
